// File: rtl/ir_seg_pkg.sv
// Shared constants, FSM encoding and helper functions for the IR-receiver
// seven-segment display path.
package ir_seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 24;
    localparam int DATA_W     = 20;
    localparam int BIT_CNT_W  = 5;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_LOAD  = 4'b0010,
        ST_SHIFT = 4'b0100,
        ST_DONE  = 4'b1000
    } conv_state_e;

    // Active-low segment patterns, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Shift-add-3 correction step: every nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        logic [3:0]       nib;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = bcd[i*4 +: 4];
            if (nib >= 4'd5) begin
                res[i*4 +: 4] = nib + 4'd3;
            end else begin
                res[i*4 +: 4] = nib;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ir_seg_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle) with
// saturation of out-of-range inputs.
module bin2bcd_seq
    import ir_seg_pkg::*;
#(
    parameter logic [DATA_W-1:0] NUM_MAX = 20'd999_999
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              load,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd_out
);

    conv_state_e           state_q, state_d;
    logic [DATA_W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bin_q     <= {DATA_W{1'b0}};
            bcd_q     <= {BCD_W{1'b0}};
            bit_cnt_q <= {BIT_CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD:  state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (bit_cnt_q == 5'd19) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Load/saturate the source, then adjust-and-shift MSB first
    always_comb begin
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (din > NUM_MAX) begin
                    bin_d = NUM_MAX;
                end else begin
                    bin_d = din;
                end
                bcd_d     = {BCD_W{1'b0}};
                bit_cnt_d = {BIT_CNT_W{1'b0}};
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adjust(bcd_q), bin_q} << 1;
                bit_cnt_d      = bit_cnt_q + 5'd1;
            end
            default: begin
                bin_d     = bin_q;
                bcd_d     = bcd_q;
                bit_cnt_d = bit_cnt_q;
            end
        endcase
    end

    // Handshake outputs decoded from the one-hot state
    always_comb begin
        load = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state_q)
            ST_IDLE:  busy = 1'b0;
            ST_LOAD:  load = 1'b1;
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  busy = 1'b1;
        endcase
    end

    assign bcd_out = bcd_q;

endmodule

// File: rtl/ir_seg_display.sv
// Six-digit multiplexed 7-segment driver for the IR receiver data word.
// Optional macro SEG_ZERO_BLANK_EN blanks leading-zero digits (digit 0 always lit).
module ir_seg_display
    import ir_seg_pkg::*;
#(
    parameter int unsigned CNT_DIGIT_MAX = 49_999,
    parameter int unsigned NUM_MAX       = 999_999
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [5:0]        point,
    input  logic              seg_en,
    output logic [5:0]        sel,
    output logic [7:0]        seg
);

    localparam int CNT_W = (CNT_DIGIT_MAX > 0) ? $clog2(CNT_DIGIT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX_C = CNT_W'(CNT_DIGIT_MAX);
    localparam logic [DATA_W-1:0] NUM_MAX_C = DATA_W'(NUM_MAX);
`ifdef SEG_ZERO_BLANK_EN
    localparam logic [5:0] BLANK_RST = 6'b111110;
`else
    localparam logic [5:0] BLANK_RST = 6'b000000;
`endif

    logic [DATA_W-1:0] data_reg_q, data_reg_d;
    logic [BCD_W-1:0]  bcd_disp_q, bcd_disp_d;
    logic [5:0]        blank_q, blank_d;
    logic [CNT_W-1:0]  cnt_digit_q, cnt_digit_d;
    logic [2:0]        digit_idx_q, digit_idx_d;
    logic [5:0]        sel_q, sel_d;
    logic [7:0]        seg_q, seg_d;

    logic              conv_start_s;
    logic              conv_load_s;
    logic              conv_busy_s;
    logic              conv_done_s;
    logic [BCD_W-1:0]  conv_bcd_s;
    logic [3:0]        nib_s;

    // Only start a new conversion from idle; a mid-flight change is caught afterwards
    assign conv_start_s = (data != data_reg_q) && !conv_busy_s;

    bin2bcd_seq #(
        .NUM_MAX (NUM_MAX_C)
    ) u_bin2bcd (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .start   (conv_start_s),
        .din     (data),
        .load    (conv_load_s),
        .busy    (conv_busy_s),
        .done    (conv_done_s),
        .bcd_out (conv_bcd_s)
    );

    // Capture, display value, scan counters and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_reg_q  <= {DATA_W{1'b0}};
            bcd_disp_q  <= {BCD_W{1'b0}};
            blank_q     <= BLANK_RST;
            cnt_digit_q <= {CNT_W{1'b0}};
            digit_idx_q <= 3'd0;
            sel_q       <= 6'b000001;
            seg_q       <= 8'hC0;
        end else begin
            data_reg_q  <= data_reg_d;
            bcd_disp_q  <= bcd_disp_d;
            blank_q     <= blank_d;
            cnt_digit_q <= cnt_digit_d;
            digit_idx_q <= digit_idx_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    // Accept the new value and publish complete conversions only
    always_comb begin
        data_reg_d = data_reg_q;
        bcd_disp_d = bcd_disp_q;
        blank_d    = blank_q;
        if (conv_load_s) begin
            data_reg_d = data;
        end else begin
            data_reg_d = data_reg_q;
        end
        if (conv_done_s) begin
            bcd_disp_d = conv_bcd_s;
`ifdef SEG_ZERO_BLANK_EN
            blank_d    = lead_zero_mask(conv_bcd_s);
`else
            blank_d    = 6'b000000;
`endif
        end else begin
            bcd_disp_d = bcd_disp_q;
            blank_d    = blank_q;
        end
    end

`ifdef SEG_ZERO_BLANK_EN
    // A digit is blank while it and every more significant digit are zero
    function automatic logic [5:0] lead_zero_mask(input logic [BCD_W-1:0] bcd);
        logic [5:0] mask;
        logic       lead;
        mask = 6'b000000;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead    = lead & (bcd[i*4 +: 4] == 4'd0);
            mask[i] = lead;
        end
        return mask;
    endfunction
`endif

    // Digit scan timing
    always_comb begin
        cnt_digit_d = cnt_digit_q;
        digit_idx_d = digit_idx_q;
        if (cnt_digit_q == CNT_MAX_C) begin
            cnt_digit_d = {CNT_W{1'b0}};
            if (digit_idx_q == 3'd5) begin
                digit_idx_d = 3'd0;
            end else begin
                digit_idx_d = digit_idx_q + 3'd1;
            end
        end else begin
            cnt_digit_d = cnt_digit_q + {{(CNT_W-1){1'b0}}, 1'b1};
            digit_idx_d = digit_idx_q;
        end
    end

    // Segment/select decode for the current digit
    always_comb begin
        nib_s = bcd_disp_q[{digit_idx_q, 2'b00} +: 4];
        sel_d = 6'b000000;
        seg_d = 8'hFF;
        if (seg_en) begin
            sel_d = 6'b000001 << digit_idx_q;
            if (blank_q[digit_idx_q]) begin
                seg_d = {~point[digit_idx_q], SEG_BLANK};
            end else begin
                seg_d = {~point[digit_idx_q], seg_code(nib_s)};
            end
        end else begin
            sel_d = 6'b000000;
            seg_d = 8'hFF;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule
